qspi_bus_arbiter: RTL and testbench

//  Shares the single QSPI pin set (sd[3:0], sck, flash/ram_a/ram_b selects) between two masters:

---
 rtl/qspi_bus_arbiter_pkg.sv | 24 ++
 rtl/arb_hold_timer.sv | 30 +++
 rtl/qspi_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_qspi_bus_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/qspi_bus_arbiter_pkg.sv
// Shared state encoding and idle-pin constants for the QSPI bus arbiter.
// The board top also uses these constants for its pad defaults.
package qspi_bus_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN0  = 2'd1;
  localparam logic [1:0] ST_OWN1  = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

  localparam logic       IDLE_SEL  = 1'b1;
  localparam logic       IDLE_SCK  = 1'b0;
  localparam logic [3:0] IDLE_OE   = 4'h0;
  localparam logic [3:0] IDLE_DATA = 4'h0;

  // Winner on contention is whoever did not own the bus last.
  function automatic logic pick_req(
    input logic r0,
    input logic r1,
    input logic last
  );
    return (r0 && r1) ? ~last : (r1 && !r0);
  endfunction

endpackage

// File: rtl/arb_hold_timer.sv
// Saturating up-counter with a terminal-count flag.
// Serves as both the starvation timer and the guard-gap counter.
module arb_hold_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (r_cnt == LIM);

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Two-master QSPI pin arbiter: whole-transaction grants, guard gap,
// round-robin on contention, starvation yield and protocol-error flag.
module qspi_bus_arbiter
  import qspi_bus_arbiter_pkg::*;
#(
  parameter int GUARD_CYCLES = 2,
  parameter int HOLD_LIMIT   = 255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       yield0,
  output logic       yield1,
  input  logic [3:0] dout_0,
  input  logic [3:0] doe_0,
  input  logic       sck_0,
  input  logic       flash_sel_0,
  input  logic       ram_a_sel_0,
  input  logic       ram_b_sel_0,
  input  logic [3:0] dout_1,
  input  logic [3:0] doe_1,
  input  logic       sck_1,
  input  logic       flash_sel_1,
  input  logic       ram_a_sel_1,
  input  logic       ram_b_sel_1,
  output logic [3:0] spi_data_out,
  output logic [3:0] spi_data_oe,
  output logic       spi_clk_out,
  output logic       spi_flash_select,
  output logic       spi_ram_a_select,
  output logic       spi_ram_b_select,
  output logic       protocol_err
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_last;
  logic       r_perr;
  logic       r_yield;

  logic       w_own0;
  logic       w_own1;
  logic       w_own;
  logic       w_any;
  logic [1:0] w_grant_st;
  logic       w_drop0;
  logic       w_drop1;
  logic       w_sel_low0;
  logic       w_sel_low1;
  logic       w_wait;
  logic       w_hold_hit;
  logic       w_hold_raw;
  logic       w_guard_done;

  assign w_own0     = (r_state == ST_OWN0);
  assign w_own1     = (r_state == ST_OWN1);
  assign w_own      = w_own0 | w_own1;
  assign w_any      = req0 | req1;
  assign w_grant_st = pick_req(req0, req1, r_last) ? ST_OWN1 : ST_OWN0;
  assign w_drop0    = w_own0 & ~req0;
  assign w_drop1    = w_own1 & ~req1;
  assign w_sel_low0 = ~(flash_sel_0 & ram_a_sel_0 & ram_b_sel_0);
  assign w_sel_low1 = ~(flash_sel_1 & ram_a_sel_1 & ram_b_sel_1);
  assign w_wait     = (w_own0 & req1) | (w_own1 & req0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = w_grant_st;
      ST_OWN0:  if (!req0) w_state_nxt = ST_GUARD;
      ST_OWN1:  if (!req1) w_state_nxt = ST_GUARD;
      ST_GUARD: begin
        if (w_guard_done) begin
          w_state_nxt = w_any ? w_grant_st : ST_IDLE;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  arb_hold_timer #(
    .LIMIT (HOLD_LIMIT)
  ) u_hold (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (~w_wait | (w_state_nxt != r_state)),
    .i_inc (w_wait),
    .o_hit (w_hold_raw)
  );

  arb_hold_timer #(
    .LIMIT (GUARD_CYCLES - 1)
  ) u_guard (
    .clk   (clk),
    .rstn  (rstn),
    .i_clr (r_state != ST_GUARD),
    .i_inc (r_state == ST_GUARD),
    .o_hit (w_guard_done)
  );

  assign w_hold_hit = (HOLD_LIMIT != 0) && w_hold_raw;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_perr  <= 1'b0;
      r_yield <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_yield <= w_own && (w_state_nxt == r_state) &&
                 (r_yield || w_hold_hit);
      if (w_drop0) r_last <= 1'b0;
      if (w_drop1) r_last <= 1'b1;
      if ((w_drop0 && w_sel_low0) || (w_drop1 && w_sel_low1)) begin
        r_perr <= 1'b1;
      end
    end
  end

  assign gnt0         = w_own0;
  assign gnt1         = w_own1;
  assign yield0       = w_own0 & (r_yield | w_hold_hit);
  assign yield1       = w_own1 & (r_yield | w_hold_hit);
  assign protocol_err = r_perr;

  // Owner pins pass straight through; no pipeline stage on the data path.
  always_comb begin
    spi_data_out     = IDLE_DATA;
    spi_data_oe      = IDLE_OE;
    spi_clk_out      = IDLE_SCK;
    spi_flash_select = IDLE_SEL;
    spi_ram_a_select = IDLE_SEL;
    spi_ram_b_select = IDLE_SEL;
    case (r_state)
      ST_OWN0: begin
        spi_data_out     = dout_0;
        spi_data_oe      = doe_0;
        spi_clk_out      = sck_0;
        spi_flash_select = flash_sel_0;
        spi_ram_a_select = ram_a_sel_0;
        spi_ram_b_select = ram_b_sel_0;
      end
      ST_OWN1: begin
        spi_data_out     = dout_1;
        spi_data_oe      = doe_1;
        spi_clk_out      = sck_1;
        spi_flash_select = flash_sel_1;
        spi_ram_a_select = ram_a_sel_1;
        spi_ram_b_select = ram_b_sel_1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Scoreboard bench for qspi_bus_arbiter: expectations are queued per
// cycle when stimulus is driven and compared on the falling edge.
module tb_qspi_bus_arbiter;

  logic       clk;
  logic       rstn;
  logic       req0, req1;
  logic       gnt0, gnt1, yield0, yield1;
  logic [3:0] dout_0, doe_0, dout_1, doe_1;
  logic       sck_0, flash_sel_0, ram_a_sel_0, ram_b_sel_0;
  logic       sck_1, flash_sel_1, ram_a_sel_1, ram_b_sel_1;
  logic [3:0] spi_data_out, spi_data_oe;
  logic       spi_clk_out;
  logic       spi_flash_select, spi_ram_a_select, spi_ram_b_select;
  logic       protocol_err;

  qspi_bus_arbiter #(
    .GUARD_CYCLES (2),
    .HOLD_LIMIT   (4)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .req0             (req0),
    .req1             (req1),
    .gnt0             (gnt0),
    .gnt1             (gnt1),
    .yield0           (yield0),
    .yield1           (yield1),
    .dout_0           (dout_0),
    .doe_0            (doe_0),
    .sck_0            (sck_0),
    .flash_sel_0      (flash_sel_0),
    .ram_a_sel_0      (ram_a_sel_0),
    .ram_b_sel_0      (ram_b_sel_0),
    .dout_1           (dout_1),
    .doe_1            (doe_1),
    .sck_1            (sck_1),
    .flash_sel_1      (flash_sel_1),
    .ram_a_sel_1      (ram_a_sel_1),
    .ram_b_sel_1      (ram_b_sel_1),
    .spi_data_out     (spi_data_out),
    .spi_data_oe      (spi_data_oe),
    .spi_clk_out      (spi_clk_out),
    .spi_flash_select (spi_flash_select),
    .spi_ram_a_select (spi_ram_a_select),
    .spi_ram_b_select (spi_ram_b_select),
    .protocol_err     (protocol_err)
  );

  typedef struct {
    int          cyc;
    string       tag;
    logic [16:0] val;
  } sb_t;

  sb_t         sb[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int          cyc     = 0;
  int          s       = 0;
  logic [16:0] obs;

  localparam logic [11:0] P_IDLE = 12'hE00;

  assign obs = {protocol_err, yield1, yield0, gnt1, gnt0,
                spi_flash_select, spi_ram_a_select, spi_ram_b_select,
                spi_clk_out, spi_data_oe, spi_data_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [16:0] got,
                       input logic [16:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].tag, obs, sb[i].val);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  function automatic logic [16:0] mk(input logic e, input logic y1,
    input logic y0, input logic g1, input logic g0,
    input logic [11:0] p);
    return {e, y1, y0, g1, g0, p};
  endfunction

  task automatic ex(input int rel, input string tag,
                    input logic [16:0] v);
    sb.push_back('{s + rel, tag, v});
  endtask

  task automatic set_p0(input logic [11:0] p);
    {flash_sel_0, ram_a_sel_0, ram_b_sel_0, sck_0, doe_0, dout_0} = p;
  endtask

  task automatic set_p1(input logic [11:0] p);
    {flash_sel_1, ram_a_sel_1, ram_b_sel_1, sck_1, doe_1, dout_1} = p;
  endtask

  task automatic go(input int rel);
    while (cyc < s + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    set_p0(12'h7FA);
    set_p1(12'hE35);
    #3;
    check("reset", obs, mk(0, 0, 0, 0, 0, P_IDLE));
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // single owner, guard gap, then the other side
    s = cyc;
    ex(1,  "s1_gnt0",   mk(0, 0, 0, 0, 1, 12'h7FA));
    ex(5,  "s1_hold",   mk(0, 0, 0, 0, 1, 12'h7FA));
    ex(6,  "s1_track",  mk(0, 0, 0, 0, 1, 12'hE5C));
    ex(10, "s1_drop",   mk(0, 0, 0, 0, 1, 12'hE5C));
    ex(11, "s1_rel",    mk(0, 0, 0, 0, 0, P_IDLE));
    ex(12, "s1_guard",  mk(0, 0, 0, 0, 0, P_IDLE));
    ex(13, "s1_gnt1",   mk(0, 0, 0, 1, 0, 12'hE35));
    ex(16, "s1_rel1",   mk(0, 0, 0, 0, 0, P_IDLE));
    req0 = 1'b1;
    go(6);  set_p0(12'hE5C);
    go(10); req0 = 1'b0;
    go(11); req1 = 1'b1;
    go(15); req1 = 1'b0;
    go(20);

    // protocol error on release, then async reset mid-ownership
    s = cyc;
    ex(1, "s6_gnt0",  mk(0, 0, 0, 0, 1, 12'hBFA));
    ex(2, "s6_drop",  mk(0, 0, 0, 0, 1, 12'hBFA));
    ex(3, "s6_perr",  mk(1, 0, 0, 0, 0, P_IDLE));
    ex(4, "s6_guard", mk(1, 0, 0, 0, 0, P_IDLE));
    ex(5, "s6_gnt1",  mk(1, 0, 0, 1, 0, 12'hE35));
    ex(6, "s6_fsel",  mk(1, 0, 0, 1, 0, 12'h635));
    set_p0(12'hBFA);
    req0 = 1'b1;
    req1 = 1'b1;
    go(2); req0 = 1'b0;
    go(6); set_p1(12'h635);
    go(7);
    #2 rstn = 1'b0;
    #1 check("async_rst", obs, mk(0, 0, 0, 0, 0, P_IDLE));
    req0 = 1'b1;
    req1 = 1'b1;
    set_p0(12'hE5C);
    set_p1(12'hE35);
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;

    // contention from reset release, yield, alternation
    s = cyc;
    ex(1,  "s2_first0", mk(0, 0, 0, 0, 1, 12'hE5C));
    ex(4,  "s2_noyld",  mk(0, 0, 0, 0, 1, 12'hE5C));
    ex(5,  "s2_yield0", mk(0, 0, 1, 0, 1, 12'hE5C));
    ex(6,  "s2_rel",    mk(0, 0, 0, 0, 0, P_IDLE));
    ex(7,  "s2_guard",  mk(0, 0, 0, 0, 0, P_IDLE));
    ex(8,  "s2_gnt1",   mk(0, 0, 0, 1, 0, 12'hE35));
    ex(11, "s3_noyld1", mk(0, 0, 0, 1, 0, 12'hE35));
    ex(12, "s3_rel1",   mk(0, 0, 0, 0, 0, P_IDLE));
    ex(14, "s3_alt0",   mk(0, 0, 0, 0, 1, 12'hE5C));
    ex(17, "s3_noyld0", mk(0, 0, 0, 0, 1, 12'hE5C));
    ex(20, "s3_alt1",   mk(0, 0, 0, 1, 0, 12'hE35));
    ex(24, "s3_rel1b",  mk(0, 0, 0, 0, 0, P_IDLE));
    ex(26, "s3_alt0b",  mk(0, 0, 0, 0, 1, 12'hE5C));
    ex(29, "s4_pre",    mk(0, 0, 0, 0, 1, 12'hE5C));
    ex(30, "s4_yield",  mk(0, 0, 1, 0, 1, 12'hE5C));
    ex(32, "s4_held",   mk(0, 0, 1, 0, 1, 12'hE5C));
    ex(34, "s4_clear",  mk(0, 0, 0, 0, 0, P_IDLE));
    go(5);  req0 = 1'b0;
    go(8);  req0 = 1'b1;
    go(11); req1 = 1'b0;
    go(12); req1 = 1'b1;
    go(17); req0 = 1'b0;
    go(18); req0 = 1'b1;
    go(23); req1 = 1'b0;
    go(24); req1 = 1'b1;
    go(31); req1 = 1'b0;
    go(33); req0 = 1'b0;
    go(40);

    check("sb_left", 17'(sb.size()), 17'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
